// File: rtl/sad_result_bram_writer.sv
// ============================================================================
// sad_result_bram_writer : packs SAD disparity bytes four per word into BRAM
// Optional: SAD_WR_BOUND_CHECK_EN suppresses writes past MAX_WORDS
// Revision: 1.0
// ============================================================================
`default_nettype none

module sad_result_bram_writer #(
  parameter int unsigned MAX_WORDS = 19200,
  parameter int unsigned WCNT_W    = 16
) (
  input  logic              axi_clk,
  input  logic              axi_rst,
  input  logic [31:0]       base_addr,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic              busy,
  output logic              frame_done,
  output logic [WCNT_W-1:0] words_written,
  output logic              overflow,
  output logic [31:0]       addr_BRAM,
  output logic              clk_BRAM,
  output logic [31:0]       dout_BRAM,
  output logic              en_BRAM,
  output logic [3:0]        we_BRAM,
  output logic              rst_BRAM
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PACK  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]  state;
  logic [31:0] ptr;
  logic [1:0]  lane;
  logic [31:0] word;
  logic [3:0]  mask;
  logic        last_pending;
  logic [31:0] word_nxt;
  logic [3:0]  mask_nxt;
  logic        accept;
  logic        suppress;

  assign accept     = (state == S_PACK) && in_valid;
  assign in_ready   = (state == S_PACK);
  assign busy       = (state != S_IDLE);
  assign frame_done = (state == S_DONE);
  assign clk_BRAM   = axi_clk;
  assign rst_BRAM   = ~axi_rst;

  always_comb begin
    word_nxt = word;
    word_nxt[{lane, 3'b000} +: 8] = in_data;
    mask_nxt = mask | (4'b0001 << lane);
  end

`ifdef SAD_WR_BOUND_CHECK_EN
  // The word about to be written has index words_written within the frame.
  assign suppress = (32'(words_written) >= MAX_WORDS);
`else
  logic unused_max;
  assign unused_max = |MAX_WORDS;
  assign suppress   = 1'b0;
`endif

  always_ff @(posedge axi_clk) begin
    if (!axi_rst) begin
      state         <= S_IDLE;
      ptr           <= '0;
      lane          <= '0;
      word          <= '0;
      mask          <= '0;
      last_pending  <= 1'b0;
      words_written <= '0;
      overflow      <= 1'b0;
      addr_BRAM     <= '0;
      dout_BRAM     <= '0;
      en_BRAM       <= 1'b0;
      we_BRAM       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            ptr           <= base_addr;
            lane          <= '0;
            word          <= '0;
            mask          <= '0;
            last_pending  <= 1'b0;
            words_written <= '0;
            overflow      <= 1'b0;
            state         <= S_PACK;
          end
        end
        S_PACK: begin
          if (accept) begin
            if (lane == 2'd3 || in_last) begin
              // BRAM port is loaded on the accepting edge so the write is
              // presented for exactly the WRITE cycle.
              addr_BRAM    <= ptr;
              dout_BRAM    <= word_nxt;
              en_BRAM      <= ~suppress;
              we_BRAM      <= suppress ? 4'b0000 : mask_nxt;
              overflow     <= overflow | suppress;
              last_pending <= in_last;
              state        <= S_WRITE;
            end else begin
              word <= word_nxt;
              mask <= mask_nxt;
              lane <= lane + 2'd1;
            end
          end
        end
        S_WRITE: begin
          en_BRAM       <= 1'b0;
          we_BRAM       <= '0;
          ptr           <= ptr + 32'd4;
          words_written <= words_written + 1'b1;
          lane          <= '0;
          word          <= '0;
          mask          <= '0;
          state         <= last_pending ? S_DONE : S_PACK;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sad_result_bram_writer.sv
// Testbench for sad_result_bram_writer: directed frames with random data and
// bubbles, checked against a byte-array reference of the expected BRAM writes.
`default_nettype none

module tb_sad_result_bram_writer;

  localparam int MAXW = 2;
`ifdef SAD_WR_BOUND_CHECK_EN
  localparam bit BOUND = 1'b1;
`else
  localparam bit BOUND = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  m;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] base_addr = '0;
  logic        start = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready, busy, frame_done, overflow;
  logic [15:0] words_written;
  logic [31:0] addr_BRAM, dout_BRAM;
  logic        clk_BRAM, en_BRAM, rst_BRAM;
  logic [3:0]  we_BRAM;

  sad_result_bram_writer #(.MAX_WORDS(MAXW), .WCNT_W(16)) dut (
    .axi_clk(clk), .axi_rst(rst), .base_addr(base_addr), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .busy(busy), .frame_done(frame_done),
    .words_written(words_written), .overflow(overflow),
    .addr_BRAM(addr_BRAM), .clk_BRAM(clk_BRAM), .dout_BRAM(dout_BRAM),
    .en_BRAM(en_BRAM), .we_BRAM(we_BRAM), .rst_BRAM(rst_BRAM)
  );

  always #5 clk = ~clk;

  int  compared = 0;
  int  mismatched = 0;
  int  cyc = 0;
  int  done_cnt = 0;
  int  done_cyc = 0;
  int  last_wr_cyc = 0;
  int  en_viol = 0;
  logic prev_en = 1'b0;
  wr_t got_q[$];
  wr_t exp_q[$];
  logic [7:0] bytes[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Passive monitor of the BRAM port; writes must be single isolated cycles
  // while the block is busy and not accepting bytes.
  always @(negedge clk) begin
    if (rst) begin
      if (en_BRAM) begin
        got_q.push_back('{addr_BRAM, dout_BRAM, we_BRAM});
        last_wr_cyc <= cyc;
        if (in_ready || !busy || prev_en) en_viol <= en_viol + 1;
      end
      if (!en_BRAM && we_BRAM != 4'b0000) en_viol <= en_viol + 1;
      if (frame_done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
    end
    prev_en <= en_BRAM;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_addr"}, addr_BRAM, 0);
    check({tag, "_dout"}, dout_BRAM, 0);
    check({tag, "_en_we"}, {en_BRAM, we_BRAM}, 0);
    check({tag, "_ready_busy_done"}, {in_ready, busy, frame_done}, 0);
    check({tag, "_wcnt_ovf"}, {words_written, overflow}, 0);
    check({tag, "_rst_bram"}, rst_BRAM, 1);
  endtask

  task automatic start_frame(input logic [31:0] base);
    @(negedge clk);
    base_addr = base;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    base_addr = $urandom;
    check("busy_rise", busy, 1);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last, input bit bub);
    bit got;
    int n;
    if (bub) begin
      n = $urandom_range(0, 3);
      repeat (n) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        in_last  = 1'($urandom);
        @(posedge clk);
        #1;
      end
    end
    in_data  = d;
    in_last  = last;
    in_valid = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
    end
    if (!got) check("ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Expected writes straight from the byte list: word w holds bytes 4w..4w+3
  // little-endian at base+4w, tail lanes zero and unmasked.
  task automatic build_expected(input logic [31:0] base);
    int n;
    int nw;
    wr_t e;
    n = bytes.size();
    nw = (n + 3) / 4;
    exp_q.delete();
    for (int w = 0; w < nw; w++) begin
      e.a = base + 32'(4 * w);
      e.d = '0;
      e.m = '0;
      for (int j = 0; j < 4; j++) begin
        if (4 * w + j < n) begin
          e.d[8*j +: 8] = bytes[4*w+j];
          e.m[j] = 1'b1;
        end
      end
      if (!(BOUND && w >= MAXW)) exp_q.push_back(e);
    end
  endtask

  task automatic run_frame(input string tag, input logic [31:0] base, input bit bub, input bit poke_start);
    int q0, d0, v0, nw, ng;
    bit got;
    build_expected(base);
    nw = (bytes.size() + 3) / 4;
    q0 = got_q.size();
    d0 = done_cnt;
    v0 = en_viol;
    start_frame(base);
    for (int i = 0; i < bytes.size(); i++) begin
      if (poke_start && i == bytes.size() / 2) begin
        start = 1'b1;
        base_addr = 32'hDEAD_0000;
        @(posedge clk);
        #1;
        start = 1'b0;
      end
      send_byte(bytes[i], (i == bytes.size() - 1), bub);
    end
    got = 1'b0;
    for (int t = 0; t < 30 && !got; t++) begin
      @(negedge clk);
      if (frame_done) got = 1'b1;
    end
    check({tag, "_done_seen"}, got, 1);
    @(negedge clk);
    check({tag, "_idle_after"}, {busy, frame_done}, 0);
    ng = got_q.size() - q0;
    check({tag, "_nwrites"}, ng, exp_q.size());
    for (int i = 0; i < ng && i < exp_q.size(); i++) begin
      check({tag, "_addr"}, got_q[q0+i].a, exp_q[i].a);
      check({tag, "_data"}, got_q[q0+i].d, exp_q[i].d);
      check({tag, "_we"}, got_q[q0+i].m, exp_q[i].m);
    end
    check({tag, "_wcnt"}, words_written, 16'(nw));
    check({tag, "_ovf"}, overflow, (BOUND && nw > MAXW));
    check({tag, "_done_once"}, done_cnt - d0, 1);
    check({tag, "_en_rules"}, en_viol - v0, 0);
    if (exp_q.size() == nw) check({tag, "_done_lat"}, done_cyc, last_wr_cyc + 1);
  endtask

  initial begin
    // Reset then idle
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b1;
    repeat (6) @(negedge clk);
    check("idle_no_write", got_q.size(), 0);
    check("idle_ready", in_ready, 0);

    // Full word
    bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_frame("full", 32'h100, 1'b0, 1'b0);

    // Partial tail
    bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    run_frame("tail", 32'h0000_4000, 1'b0, 1'b0);

    // 40 random bytes with bubbles and an ignored mid-frame start
    bytes.delete();
    for (int i = 0; i < 40; i++) bytes.push_back(8'($urandom));
    run_frame("bubbles", {$urandom_range(0, 32'h00FF_FFFF), 2'b00}, 1'b1, 1'b1);

    // Reset mid-frame
    begin
      int q0;
      q0 = got_q.size();
      start_frame(32'h0000_0900);
      send_byte(8'hAA, 1'b0, 1'b0);
      send_byte(8'hBB, 1'b0, 1'b0);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_reset_vals("midrst");
      rst = 1'b1;
      check("midrst_no_write", got_q.size() - q0, 0);
    end
    bytes = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
    run_frame("after_rst", 32'h200, 1'b0, 1'b0);

    // Twelve bytes: exceeds MAX_WORDS when bound checking is compiled in
    bytes.delete();
    for (int i = 0; i < 12; i++) bytes.push_back(8'($urandom));
    run_frame("bound", 32'h300, 1'b1, 1'b0);

    // Pointer wrap at 2^32
    bytes.delete();
    for (int i = 0; i < 9; i++) bytes.push_back(8'($urandom));
    run_frame("wrap", 32'hFFFF_FFF8, 1'b1, 1'b0);

    // Random short frames, each tail length
    for (int f = 0; f < 4; f++) begin
      bytes.delete();
      for (int i = 0; i < 1 + f; i++) bytes.push_back(8'($urandom));
      run_frame("rand", {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, 1'b1, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
